// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing the single L1-to-L2 read port between the instruction
// (INS) and data (DAT) caches, with one transaction outstanding at a time.
module l2_request_arbiter #(
    parameter int   ADDRESS_WIDTH = 32,
    parameter int   L2_BUS_WIDTH  = 32,
    parameter logic HIGH          = 1'b1,
    parameter logic LOW           = 1'b0
) (
    input  logic                       CLK,
    input  logic                       RST,

    input  logic                       ADDRESS_TO_L2_VALID_INS,
    input  logic [ADDRESS_WIDTH-3:0]   ADDRESS_TO_L2_INS,
    output logic                       ADDRESS_TO_L2_READY_INS,
    output logic                       DATA_FROM_L2_VALID_INS,
    output logic [L2_BUS_WIDTH-1:0]    DATA_FROM_L2_INS,
    input  logic                       DATA_FROM_L2_READY_INS,

    input  logic                       ADDRESS_TO_L2_VALID_DAT,
    input  logic [ADDRESS_WIDTH-3:0]   ADDRESS_TO_L2_DAT,
    output logic                       ADDRESS_TO_L2_READY_DAT,
    output logic                       DATA_FROM_L2_VALID_DAT,
    output logic [L2_BUS_WIDTH-1:0]    DATA_FROM_L2_DAT,
    input  logic                       DATA_FROM_L2_READY_DAT,

    output logic                       ADDRESS_TO_L2_VALID,
    output logic [ADDRESS_WIDTH-3:0]   ADDRESS_TO_L2,
    input  logic                       ADDRESS_TO_L2_READY,
    input  logic                       DATA_FROM_L2_VALID,
    input  logic [L2_BUS_WIDTH-1:0]    DATA_FROM_L2,
    output logic                       DATA_FROM_L2_READY,

    output logic                       GRANT_DAT,
    output logic [1:0]                 STATE_DEBUG
);

    // Every channel is valid/ready: a transfer happens on the rising edge where both
    // are high; the sender holds valid and payload stable until it sees ready.

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;

    logic [1:0]               state;
    logic [ADDRESS_WIDTH-3:0] addr_q;
    logic [L2_BUS_WIDTH-1:0]  data_ins_q;
    logic [L2_BUS_WIDTH-1:0]  data_dat_q;
    logic                     owner;
    logic                     last_grant;

    logic                     req_any;
    logic                     win_dat;
    logic                     owner_ready;

    assign req_any = ADDRESS_TO_L2_VALID_INS | ADDRESS_TO_L2_VALID_DAT;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win_dat = LOW;
        case ({ADDRESS_TO_L2_VALID_INS, ADDRESS_TO_L2_VALID_DAT})
            2'b01:   win_dat = HIGH;
            2'b11:   win_dat = ~last_grant;
            default: win_dat = LOW;
        endcase
    end

    assign owner_ready = owner ? DATA_FROM_L2_READY_DAT : DATA_FROM_L2_READY_INS;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (req_any)             state <= ST_ISSUE;
                ST_ISSUE:  if (ADDRESS_TO_L2_READY) state <= ST_WAIT;
                ST_WAIT:   if (DATA_FROM_L2_VALID)  state <= ST_RETURN;
                ST_RETURN: if (owner_ready)         state <= ST_IDLE;
                default:                            state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q     <= '0;
            owner      <= LOW;
            last_grant <= HIGH;
        end else if (state == ST_IDLE && req_any) begin
            addr_q     <= win_dat ? ADDRESS_TO_L2_DAT : ADDRESS_TO_L2_INS;
            owner      <= win_dat;
            last_grant <= win_dat;
        end
    end

    // Response goes into the owner's register only, so the other side keeps its last value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_ins_q <= '0;
            data_dat_q <= '0;
        end else if (state == ST_WAIT && DATA_FROM_L2_VALID) begin
            if (owner) data_dat_q <= DATA_FROM_L2;
            else       data_ins_q <= DATA_FROM_L2;
        end
    end

    // Ready is combinational from the requesters' valids, so it is gated while in reset.
    assign ADDRESS_TO_L2_READY_INS = ~RST & (state == ST_IDLE) & req_any & ~win_dat;
    assign ADDRESS_TO_L2_READY_DAT = ~RST & (state == ST_IDLE) & req_any &  win_dat;

    assign ADDRESS_TO_L2_VALID     = (state == ST_ISSUE);
    assign ADDRESS_TO_L2           = addr_q;
    assign DATA_FROM_L2_READY      = (state == ST_WAIT);

    assign DATA_FROM_L2_VALID_INS  = (state == ST_RETURN) & ~owner;
    assign DATA_FROM_L2_VALID_DAT  = (state == ST_RETURN) &  owner;
    assign DATA_FROM_L2_INS        = data_ins_q;
    assign DATA_FROM_L2_DAT        = data_dat_q;

    assign GRANT_DAT               = owner;
    assign STATE_DEBUG             = state;

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Shares the single L1-to-L2 read port between the instruction cache (INS) and the data cache (DAT).
- Accepts one address request at a time, using round-robin priority, and forwards it to L2.
- Captures the L2 response and routes it back to the requester that issued it.
- Sits between both L1 caches and the L2 cache. Only one transaction is outstanding at any time.

Parameters:
- ADDRESS_WIDTH, 32: byte-address width. Word addresses are ADDRESS_WIDTH-2 bits.
- L2_BUS_WIDTH, 32: width of the L2 data return bus.
- HIGH, 1'b1: logic-high constant.
- LOW, 1'b0: logic-low constant.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- ADDRESS_TO_L2_VALID_INS  input  1  INS request valid.
- ADDRESS_TO_L2_INS  input  ADDRESS_WIDTH-2  INS word address.
- ADDRESS_TO_L2_READY_INS  output  1  INS request accepted.
- DATA_FROM_L2_VALID_INS  output  1  response valid to INS.
- DATA_FROM_L2_INS  output  L2_BUS_WIDTH  response data to INS.
- DATA_FROM_L2_READY_INS  input  1  INS accepts the response.
- ADDRESS_TO_L2_VALID_DAT, ADDRESS_TO_L2_DAT, ADDRESS_TO_L2_READY_DAT, DATA_FROM_L2_VALID_DAT, DATA_FROM_L2_DAT, DATA_FROM_L2_READY_DAT: same as the INS ports, for the DAT requester.
- ADDRESS_TO_L2_VALID  output  1  request valid to L2.
- ADDRESS_TO_L2  output  ADDRESS_WIDTH-2  word address to L2.
- ADDRESS_TO_L2_READY  input  1  L2 accepts the address.
- DATA_FROM_L2_VALID  input  1  L2 response valid.
- DATA_FROM_L2  input  L2_BUS_WIDTH  L2 response data.
- DATA_FROM_L2_READY  output  1  arbiter accepts the L2 response.
- GRANT_DAT  output  1  owner of the current transaction: 0 = INS, 1 = DAT.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RETURN. State, address register, data register, owner and last_grant are all registered.
- Reset (asynchronous, any state, including mid-transaction):
  - state = IDLE; all VALID and READY outputs = 0.
  - ADDRESS_TO_L2 = 0; both DATA_FROM_L2_x outputs = 0; GRANT_DAT = 0.
  - last_grant = DAT, so INS wins the first tie.
  - Any in-flight transaction is dropped; L2 is reset with the same RST.
- IDLE:
  - ADDRESS_TO_L2_READY_x is combinational and is 1 only for the arbitration winner.
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - On the handshake edge: latch the winner's address into the address register, set owner and last_grant to the winner, go to ISSUE.
  - Neither requester valid: stay in IDLE; both READYs = 0.
- ISSUE:
  - ADDRESS_TO_L2_VALID = 1 and ADDRESS_TO_L2 = latched address, both held stable until ADDRESS_TO_L2_READY = 1.
  - On that edge go to WAIT.
- WAIT:
  - DATA_FROM_L2_READY = 1.
  - On DATA_FROM_L2_VALID = 1, capture DATA_FROM_L2 into the data register and go to RETURN.
  - A DATA_FROM_L2_VALID in IDLE or ISSUE is ignored, because READY is 0 there.
- RETURN:
  - DATA_FROM_L2_VALID_<owner> = 1 and DATA_FROM_L2_<owner> = captured data, held until DATA_FROM_L2_READY_<owner> = 1, then go to IDLE.
  - The non-owner's VALID stays 0.
  - The non-owner's data output keeps its last value.
- No new request is accepted until the state is back in IDLE. IDLE to IDLE has no bubble beyond the RETURN handshake cycle.
- Minimum latency, from request handshake to response valid at the requester: 3 cycles (ISSUE 1, WAIT 1, RETURN presented).
- GRANT_DAT equals owner at all times. It is meaningful only in ISSUE, WAIT and RETURN.
- A requester may drop VALID in IDLE before it is granted; there is no penalty.
- A request that arrives while the FSM is busy waits. The requester must hold VALID and address until it sees READY.

Test Plan:
- Reset, then INS requests address 30'h0000_0010; L2 ready at once, data 32'hDEADBEEF one cycle later.
  -> READY_INS pulses at t0; ADDRESS_TO_L2 = 30'h10 at t1; INS receives DEADBEEF with VALID_INS at t3; VALID_DAT stays 0.
- INS and DAT both valid in the same cycle, with addresses 30'h4 and 30'h8, held through two transactions.
  -> INS granted first (last_grant = DAT after reset), then DAT; GRANT_DAT sequence 0 then 1.
- Both requesters held valid continuously for 4 transactions.
  -> Grants alternate INS, DAT, INS, DAT.
- L2 holds ADDRESS_TO_L2_READY low for 5 cycles, and the requester holds DATA_FROM_L2_READY_DAT low for 3 cycles.
  -> ADDRESS_TO_L2 and VALID stable for the whole stall; DAT data held stable; no second grant until RETURN completes.
- DATA_FROM_L2_VALID asserted spuriously while in IDLE.
  -> DATA_FROM_L2_READY = 0; no response delivered; state stays IDLE.
- RST asserted in WAIT with the transaction outstanding.
  -> Outputs go to reset values immediately, without a clock edge; the next transaction after release proceeds normally, with INS winning a tie.
